// File: rtl/jtag_deser_pkg.sv
// Shared types and default constants for the JTAG USER-DR byte deserializer.
package jtag_deser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_SHIFTING = 2'd2
    } deser_state_e;

    localparam int DEFAULT_BYTE_WIDTH  = 8;
    localparam int DEFAULT_COUNT_WIDTH = 16;

endpackage

// File: rtl/jtag_byte_deserializer_if.sv
// TAP-side controls, serial data and assembled-byte results of the deserializer.
// master = TAP controller / consumer side, slave = deserializer.
interface jtag_byte_deserializer_if #(
    parameter int BYTE_WIDTH  = jtag_deser_pkg::DEFAULT_BYTE_WIDTH,
    parameter int COUNT_WIDTH = jtag_deser_pkg::DEFAULT_COUNT_WIDTH
);
    logic                   test_logic_reset;
    logic                   ir_is_user;
    logic                   capture_dr;
    logic                   shift_dr;
    logic                   update_dr;
    logic                   tdi;
    logic                   tdo;
    logic [BYTE_WIDTH-1:0]  byte_data;
    logic                   byte_valid;
    logic                   frame_done;
    logic                   partial_err;
    logic [COUNT_WIDTH-1:0] byte_count;

    modport master (
        output test_logic_reset, ir_is_user, capture_dr, shift_dr, update_dr, tdi,
        input  tdo, byte_data, byte_valid, frame_done, partial_err, byte_count
    );

    modport slave (
        input  test_logic_reset, ir_is_user, capture_dr, shift_dr, update_dr, tdi,
        output tdo, byte_data, byte_valid, frame_done, partial_err, byte_count
    );
endinterface

// File: rtl/jtag_byte_deserializer.sv
// Assembles LSB-first TDI bits of a USER DR scan into bytes with strobes and frame status.
// Define DESER_LOOPBACK_EN to echo TDI on TDO one shift cycle later; otherwise TDO is tied low.
module jtag_byte_deserializer
    import jtag_deser_pkg::*;
#(
    parameter int BYTE_WIDTH  = DEFAULT_BYTE_WIDTH,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic tck,
    input  logic rst_n,
    jtag_byte_deserializer_if.slave bus
);

    localparam int                     BIT_CNT_W = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0]   BIT_ZERO  = {BIT_CNT_W{1'b0}};
    localparam logic [BIT_CNT_W-1:0]   BIT_ONE   = BIT_CNT_W'(32'd1);
    localparam logic [BIT_CNT_W-1:0]   LAST_BIT  = BIT_CNT_W'(BYTE_WIDTH - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO  = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(32'd1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = {COUNT_WIDTH{1'b1}};

    deser_state_e           r_state,       w_state;
    logic [BYTE_WIDTH-1:0]  r_shift,       w_shift;
    logic [BYTE_WIDTH-1:0]  r_byte_data,   w_byte_data;
    logic [BIT_CNT_W-1:0]   r_bit_cnt,     w_bit_cnt;
    logic [COUNT_WIDTH-1:0] r_byte_count,  w_byte_count;
    logic                   r_byte_valid,  w_byte_valid;
    logic                   r_frame_done,  w_frame_done;
    logic                   r_partial_err, w_partial_err;

    logic                   w_active;
    logic                   w_in_frame;
    logic [BYTE_WIDTH-1:0]  w_shift_word;

    assign w_active     = bus.ir_is_user & ~bus.test_logic_reset;
    assign w_shift_word = {bus.tdi, r_shift[BYTE_WIDTH-1:1]};

    // Decode whether a DR frame is open; unknown encodings are treated as idle.
    always_comb begin
        w_in_frame = 1'b0;
        case (r_state)
            ST_IDLE:     w_in_frame = 1'b0;
            ST_ARMED:    w_in_frame = 1'b1;
            ST_SHIFTING: w_in_frame = 1'b1;
            default:     w_in_frame = 1'b0;
        endcase
    end

    // Next-state and datapath: TLR/non-USER > update > capture > shift.
    always_comb begin
        w_state       = r_state;
        w_shift       = r_shift;
        w_byte_data   = r_byte_data;
        w_bit_cnt     = r_bit_cnt;
        w_byte_count  = r_byte_count;
        w_byte_valid  = 1'b0;
        w_frame_done  = 1'b0;
        w_partial_err = r_partial_err;

        if (!w_active) begin
            w_state   = ST_IDLE;
            w_bit_cnt = BIT_ZERO;
        end else if (bus.update_dr) begin
            if (w_in_frame) begin
                w_state      = ST_IDLE;
                w_frame_done = 1'b1;
                w_bit_cnt    = BIT_ZERO;
                if (r_bit_cnt != BIT_ZERO) begin
                    w_partial_err = 1'b1;
                end else begin
                    w_partial_err = r_partial_err;
                end
            end else begin
                w_state = ST_IDLE;
            end
        end else if (bus.capture_dr) begin
            w_state       = ST_ARMED;
            w_bit_cnt     = BIT_ZERO;
            w_byte_count  = CNT_ZERO;
            w_partial_err = 1'b0;
        end else if (bus.shift_dr && w_in_frame) begin
            w_state = ST_SHIFTING;
            w_shift = w_shift_word;
            if (r_bit_cnt == LAST_BIT) begin
                w_bit_cnt    = BIT_ZERO;
                w_byte_data  = w_shift_word;
                w_byte_valid = 1'b1;
                if (r_byte_count != CNT_MAX) begin
                    w_byte_count = r_byte_count + CNT_ONE;
                end else begin
                    w_byte_count = r_byte_count;
                end
            end else begin
                w_bit_cnt = r_bit_cnt + BIT_ONE;
            end
        end else begin
            // Pause/Exit cycles keep the frame open; a corrupt state collapses to idle.
            w_state = w_in_frame ? r_state : ST_IDLE;
        end
    end

    // State and datapath registers.
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_shift       <= {BYTE_WIDTH{1'b0}};
            r_byte_data   <= {BYTE_WIDTH{1'b0}};
            r_bit_cnt     <= BIT_ZERO;
            r_byte_count  <= CNT_ZERO;
            r_byte_valid  <= 1'b0;
            r_frame_done  <= 1'b0;
            r_partial_err <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_shift       <= w_shift;
            r_byte_data   <= w_byte_data;
            r_bit_cnt     <= w_bit_cnt;
            r_byte_count  <= w_byte_count;
            r_byte_valid  <= w_byte_valid;
            r_frame_done  <= w_frame_done;
            r_partial_err <= w_partial_err;
        end
    end

    assign bus.byte_data   = r_byte_data;
    assign bus.byte_valid  = r_byte_valid;
    assign bus.frame_done  = r_frame_done;
    assign bus.partial_err = r_partial_err;
    assign bus.byte_count  = r_byte_count;

`ifdef DESER_LOOPBACK_EN
    logic r_tdo;

    // One-cycle TDI echo, advanced only on USER shift cycles.
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            r_tdo <= 1'b0;
        end else if (w_active && bus.shift_dr) begin
            r_tdo <= bus.tdi;
        end else begin
            r_tdo <= r_tdo;
        end
    end

    assign bus.tdo = r_tdo;
`else
    assign bus.tdo = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_byte_deserializer.sv
// Directed + randomized bench: a frame-level model (bit queue per scan) predicts every output each cycle.
module tb_jtag_byte_deserializer;

    logic tck   = 1'b0;
    logic rst_n = 1'b1;
    always #5 tck = ~tck;

    jtag_byte_deserializer_if #(.BYTE_WIDTH(8), .COUNT_WIDTH(16)) bus ();
    jtag_byte_deserializer_if #(.BYTE_WIDTH(8), .COUNT_WIDTH(2))  bus_s ();

    // Small-counter twin sees identical stimulus so saturation is reachable quickly.
    assign bus_s.test_logic_reset = bus.test_logic_reset;
    assign bus_s.ir_is_user       = bus.ir_is_user;
    assign bus_s.capture_dr       = bus.capture_dr;
    assign bus_s.shift_dr         = bus.shift_dr;
    assign bus_s.update_dr        = bus.update_dr;
    assign bus_s.tdi              = bus.tdi;

    jtag_byte_deserializer #(.BYTE_WIDTH(8), .COUNT_WIDTH(16)) dut (
        .tck(tck), .rst_n(rst_n), .bus(bus)
    );
    jtag_byte_deserializer #(.BYTE_WIDTH(8), .COUNT_WIDTH(2)) dut_s (
        .tck(tck), .rst_n(rst_n), .bus(bus_s)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: which bits of the open frame are pending, and what was last reported.
    bit          m_in_frame = 1'b0;
    bit          m_bits[$];
    logic [7:0]  exp_data   = 8'h00;
    logic        exp_valid  = 1'b0;
    logic        exp_done   = 1'b0;
    logic        exp_perr   = 1'b0;
    int          exp_count  = 0;
    int          exp_count_s = 0;
    logic        exp_tdo    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step);
        check({step, ":byte_valid"},   32'(bus.byte_valid),   32'(exp_valid));
        check({step, ":byte_data"},    32'(bus.byte_data),    32'(exp_data));
        check({step, ":frame_done"},   32'(bus.frame_done),   32'(exp_done));
        check({step, ":partial_err"},  32'(bus.partial_err),  32'(exp_perr));
        check({step, ":byte_count"},   32'(bus.byte_count),   32'(exp_count));
        check({step, ":byte_count_s"}, 32'(bus_s.byte_count), 32'(exp_count_s));
        check({step, ":tdo"},          32'(bus.tdo),          32'(exp_tdo));
    endtask

    task automatic model_reset();
        m_in_frame  = 1'b0;
        m_bits.delete();
        exp_data    = 8'h00;
        exp_valid   = 1'b0;
        exp_done    = 1'b0;
        exp_perr    = 1'b0;
        exp_count   = 0;
        exp_count_s = 0;
        exp_tdo     = 1'b0;
    endtask

    // Drive one TCK cycle, advance the model per the frame rules, then compare everything.
    task automatic tick(input string step, input bit tlr, input bit user, input bit cap,
                        input bit shf, input bit upd, input bit din);
        int v;
        bus.test_logic_reset = tlr;
        bus.ir_is_user       = user;
        bus.capture_dr       = cap;
        bus.shift_dr         = shf;
        bus.update_dr        = upd;
        bus.tdi              = din;
        @(posedge tck);
        #1;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        if (tlr || !user) begin
            m_in_frame = 1'b0;
            m_bits.delete();
        end else if (upd) begin
            if (m_in_frame) begin
                exp_done = 1'b1;
                if (m_bits.size() != 0) exp_perr = 1'b1;
                m_bits.delete();
                m_in_frame = 1'b0;
            end
        end else if (cap) begin
            m_in_frame  = 1'b1;
            m_bits.delete();
            exp_count   = 0;
            exp_count_s = 0;
            exp_perr    = 1'b0;
        end else if (shf && m_in_frame) begin
            m_bits.push_back(din);
            if (m_bits.size() == 8) begin
                v = 0;
                foreach (m_bits[i]) v += int'(m_bits[i]) * (1 << i);
                exp_data    = 8'(v);
                exp_valid   = 1'b1;
                exp_count   = (exp_count   < 65535) ? exp_count + 1   : exp_count;
                exp_count_s = (exp_count_s < 3)     ? exp_count_s + 1 : exp_count_s;
                m_bits.delete();
            end
        end
`ifdef DESER_LOOPBACK_EN
        if (user && !tlr && shf) exp_tdo = din;
`endif
        check_all(step);
    endtask

    task automatic shift_bits(input string step, input logic [31:0] val, input int n);
        for (int i = 0; i < n; i++) tick(step, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, val[i]);
    endtask

    task automatic idle(input string step, input int n);
        for (int i = 0; i < n; i++) tick(step, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset(input string step);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all(step);
        @(negedge tck);
        @(negedge tck);
        rst_n = 1'b1;
    endtask

    initial begin
        int nbits;
        bus.test_logic_reset = 1'b0;
        bus.ir_is_user       = 1'b0;
        bus.capture_dr       = 1'b0;
        bus.shift_dr         = 1'b0;
        bus.update_dr        = 1'b0;
        bus.tdi              = 1'b0;
        #3;
        apply_reset("reset");
        idle("post_reset", 2);

        // Two full bytes in one frame.
        tick("cap1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        shift_bits("f1", 32'h3E5E, 16);
        tick("upd1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle("f1_idle", 2);

        // One byte plus three stray bits flags a partial frame.
        tick("cap2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        shift_bits("f2", 32'h0000_0541, 11);
        tick("upd2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // TAP activity under a non-USER instruction is ignored.
        tick("nu_cap", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) tick("nu_shf", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'($urandom));
        tick("nu_upd", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-frame, then a fresh frame.
        tick("cap3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        shift_bits("f3a", 32'h0000_0015, 5);
        apply_reset("mid_reset");
        shift_bits("f3_nocap", 32'h0000_00FF, 3);
        tick("cap3b", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        shift_bits("f3b", 32'h0000_003C, 8);
        tick("upd3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Pause-DR in the middle of a byte.
        tick("cap4", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        shift_bits("f4a", 32'h0000_0006, 4);
        idle("pause", 4);
        shift_bits("f4b", 32'h0000_0007, 4);
        tick("upd4", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Five bytes: small-counter twin must saturate at 3.
        tick("cap5", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        shift_bits("f5a", $urandom, 32);
        shift_bits("f5b", 32'h0000_00A5, 8);
        tick("upd5", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Same-edge priority: TLR over update, update over capture, capture over shift.
        tick("cap6", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        shift_bits("f6", 32'h0000_0003, 3);
        tick("tlr_upd", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick("cap7", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        shift_bits("f7", 32'h0000_0001, 2);
        tick("upd_cap", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick("cap8", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        shift_bits("f8", 32'h0000_0005, 5);
        tick("cap_shf", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        shift_bits("f8b", 32'h0000_00C3, 8);
        tick("upd8", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Random frames with pauses, restarts, TLR and instruction changes.
        for (int f = 0; f < 30; f++) begin
            tick("rcap", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            nbits = int'($urandom_range(0, 44));
            for (int b = 0; b < nbits; b++) begin
                if ($urandom_range(0, 4) == 0) idle("rpause", int'($urandom_range(1, 3)));
                if ($urandom_range(0, 39) == 0)
                    tick("rcap_mid", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'($urandom));
                else if ($urandom_range(0, 59) == 0)
                    tick("rtlr", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'($urandom));
                else if ($urandom_range(0, 59) == 0)
                    tick("rnouser", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'($urandom));
                else
                    tick("rshf", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'($urandom));
            end
            tick("rupd", 1'b0, 1'b1, 1'($urandom_range(0, 3) == 0), 1'b0, 1'b1, 1'b0);
            idle("ridle", int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_byte_deserializer.md
JTAG_BYTE_DESERIALIZER -- requirements
Module: jtag_byte_deserializer

Interface
REQ-001 SHALL have parameter BYTE_WIDTH, default 8, bits per assembled byte.
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, width of byte_count.
REQ-003 SHALL have ports, clock and reset first:
- tck  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- test_logic_reset  in  1  TAP in Test-Logic-Reset.
- ir_is_user  in  1  IR holds the USER instruction.
- capture_dr  in  1  TAP in Capture-DR.
- shift_dr  in  1  TAP in Shift-DR.
- update_dr  in  1  TAP in Update-DR.
- tdi  in  1  serial data, LSB of each byte first.
- tdo  out  1  serial return.
- byte_data  out  BYTE_WIDTH  last assembled byte.
- byte_valid  out  1  one-cycle strobe, byte_data is new.
- frame_done  out  1  one-cycle strobe, DR scan ended.
- partial_err  out  1  sticky; frame ended mid-byte.
- byte_count  out  COUNT_WIDTH  bytes emitted in the current frame.

Function
REQ-004 SHALL implement FSM IDLE, ARMED, SHIFTING; the TAP inputs are sampled only when ir_is_user=1.
REQ-005 IDLE->ARMED on capture_dr: clear bit counter, byte_count and partial_err.
REQ-006 ARMED->SHIFTING on the first shift_dr cycle; SHIFTING persists across Exit1/Pause/Exit2 cycles, where shift_dr=0.
REQ-007 Each cycle with shift_dr=1 in ARMED or SHIFTING SHALL right-shift tdi into the MSB of the shift register and increment the bit counter modulo BYTE_WIDTH.
REQ-008 The edge sampling bit BYTE_WIDTH-1 of a byte SHALL load byte_data with the completed byte and set byte_valid for exactly one cycle; latency is 0 cycles after that edge.
REQ-009 byte_count SHALL increment with each byte_valid and saturate at 2^COUNT_WIDTH-1 with no wrap.
REQ-010 update_dr in ARMED or SHIFTING SHALL go to IDLE and pulse frame_done for one cycle.
REQ-011 If the bit counter is nonzero at update_dr, partial_err SHALL be set and the partial bits discarded; no byte_valid is issued.
REQ-012 capture_dr while in ARMED or SHIFTING SHALL restart the frame as in REQ-005, with no frame_done.
REQ-013 test_logic_reset=1, or ir_is_user=0, SHALL force IDLE and clear the bit counter on that edge. byte_data, byte_count and partial_err are retained; no strobes are issued.
REQ-014 Priority on the same edge: test_logic_reset > update_dr > capture_dr > shift_dr.
REQ-015 byte_data SHALL hold its value between strobes.

Reset
REQ-016 rst_n=0 SHALL asynchronously force:
- state IDLE;
- shift register, bit counter, byte_data, byte_count = 0;
- byte_valid, frame_done, partial_err, tdo = 0.
REQ-017 Reset deassertion SHALL be synchronous to tck; the first functional edge is the one after rst_n rises.
REQ-018 Reset mid-frame SHALL discard all in-flight bits; the next frame requires a fresh capture_dr.

Configuration
REQ-019 With macro DESER_LOOPBACK_EN defined, tdo SHALL be tdi registered on each shift_dr cycle, giving a 1-bit delayed echo; tdo holds its value otherwise.
REQ-020 Without DESER_LOOPBACK_EN, tdo SHALL be constant 0 and no loopback flop is synthesized.

Structure
REQ-021 Package jtag_deser_pkg SHALL hold the FSM state enum and default constants BYTE_WIDTH=8 and COUNT_WIDTH=16.
REQ-022 Single module: no sub-module, since the FSM and datapath share the bit counter.

Verification
REQ-023 USER IR; capture; shift 16 bits of 0x5E then 0x3E (LSB first); update.
-> byte_valid twice, with 0x5E then 0x3E; byte_count=2; frame_done once; partial_err=0.
REQ-024 Shift 11 bits: 0x41 then 3 extra bits; update.
-> one byte_valid (0x41); frame_done; partial_err=1; byte_count=1.
REQ-025 Hold ir_is_user=0 and toggle capture/shift/update.
-> no strobes; byte_count stays 0.
REQ-026 Pull rst_n low after 5 bits; release; new frame 0x3C.
-> byte_data=0x3C with byte_count=1.
REQ-027 Insert Pause-DR (shift_dr=0 for 4 cycles) after bit 3 of 0x76.
-> byte_valid with 0x76.
REQ-028 DESER_LOOPBACK_EN defined, shift 0xA5.
-> tdo sequence matches tdi delayed by one shift cycle.
Undefined: tdo=0 throughout.
